// File: rtl/idct8_serial.sv
// idct8_serial: serial 8-point IDCT, one multiply-accumulate per cycle, one sample per output handshake
// Ports: clk, rst (synchronous, active-high)
//        coef0..coef7, in_valid, in_ready     : accept one block of DCT coefficients X[0..7]
//        sample_out, sample_idx, out_valid, out_ready : emit x[0..7] in order, held until accepted
module idct8_serial #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 8,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  coef0,
    input  logic signed [IN_W-1:0]  coef1,
    input  logic signed [IN_W-1:0]  coef2,
    input  logic signed [IN_W-1:0]  coef3,
    input  logic signed [IN_W-1:0]  coef4,
    input  logic signed [IN_W-1:0]  coef5,
    input  logic signed [IN_W-1:0]  coef6,
    input  logic signed [IN_W-1:0]  coef7,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] sample_out,
    output logic [2:0]              sample_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int ACC_W = IN_W + 19;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
    // 2^FRAC * 1/2 * cos(m*pi/16) for m = 0..8, quantised at FRAC = 14
    localparam logic signed [15:0] COS [9] = '{16'sd8192, 16'sd8035, 16'sd7568, 16'sd6811,
                                               16'sd5793, 16'sd4551, 16'sd3135, 16'sd1598, 16'sd0};
    localparam logic signed [15:0] DC = 16'sd5793;
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
    state_t r_state, w_next;
    logic signed [IN_W-1:0]  r_coef [8];
    logic [2:0]              r_n, r_k;
    logic signed [ACC_W-1:0] r_acc, w_acc_next, w_rnd, w_clip;
    logic signed [15:0]      w_c;
    // The angle (2n+1)k*pi/16 is reduced mod 2*pi, folded onto [0, pi] and then
    // onto [0, pi/2] with a sign flip, so only nine magnitudes are stored.
    function automatic logic signed [15:0] cos_c(input logic [2:0] k, input logic [2:0] n);
        logic [6:0] p;
        logic [4:0] m, f;
        p = 7'({n, 1'b1}) * 7'(k);
        m = p[4:0];
        f = m > 5'd16 ? 5'd0 - m : m;
        return k == 3'd0 ? DC : f > 5'd8 ? -COS[4'(5'd16 - f)] : COS[4'(f)];
    endfunction
    assign w_c       = cos_c(r_k, r_n);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == OUT;
    always_comb begin
        w_acc_next = r_acc + ACC_W'(r_coef[r_k]) * ACC_W'(w_c);
        w_rnd      = (w_acc_next + HALF) >>> FRAC;
        w_clip     = w_rnd > SMAX ? SMAX : w_rnd < SMIN ? SMIN : w_rnd;
        w_next     = r_state == IDLE ? (in_valid ? CALC : IDLE) :
                     r_state == CALC ? (r_k == 3'd7 ? OUT : CALC) :
                     out_ready       ? (r_n == 3'd7 ? IDLE : CALC) : OUT;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_n        <= '0;
            r_k        <= '0;
            sample_out <= '0;
            sample_idx <= '0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_coef <= '{coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7};
                r_acc  <= '0;
                r_n    <= '0;
                r_k    <= '0;
            end
        end else if (r_state == CALC) begin
            r_acc <= w_acc_next;
            r_k   <= r_k + 3'd1;
            if (r_k == 3'd7) begin
                sample_out <= w_clip[OUT_W-1:0];
                sample_idx <= r_n;
            end
        end else if (out_ready) begin
            r_acc <= '0;
            r_k   <= '0;
            r_n   <= r_n + 3'd1;
        end
    end
endmodule

// File: tb/tb_idct8_serial.sv
// tb_idct8_serial: table, random-vs-model and corner-sequence checks for idct8_serial
module tb_idct8_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [18:0] c [8];
    logic in_valid = 1'b0;
    logic in_ready, out_valid;
    logic out_ready = 1'b1;
    logic signed [7:0] sample_out;
    logic [2:0] sample_idx;
    int checks = 0;
    int failures = 0;
    typedef int arr8_t [8];
    typedef struct {
        string name;
        arr8_t x;
        arr8_t e;
    } vec_t;
    vec_t tv [4];
    arr8_t dc, ac, xr, er;

    always #5 clk = ~clk;

    idct8_serial dut (
        .clk(clk), .rst(rst),
        .coef0(c[0]), .coef1(c[1]), .coef2(c[2]), .coef3(c[3]),
        .coef4(c[4]), .coef5(c[5]), .coef6(c[6]), .coef7(c[7]),
        .in_valid(in_valid), .in_ready(in_ready),
        .sample_out(sample_out), .sample_idx(sample_idx),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic int model_sample(arr8_t x, int n);
        real pi = 3.14159265358979;
        longint acc = 0;
        longint y;
        for (int k = 0; k < 8; k++) begin
            real a = k == 0 ? $sqrt(0.125) : 0.5;
            int cc = int'(16384.0 * a * $cos(real'((2 * n + 1) * k) * pi / 16.0));
            acc += longint'(x[k]) * longint'(cc);
        end
        y = (acc + 64'sd8192) >>> 14;
        y = y > 127 ? 127 : y < -128 ? -128 : y;
        return int'(y);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic accept(input arr8_t x);
        int t = 0;
        for (int i = 0; i < 8; i++) c[i] = 19'(x[i]);
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            tick;
            t++;
        end
        chk("accept_ready", int'(in_ready), 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic collect(input arr8_t e, input int nsamp, input int stall_at, input string nm);
        for (int s = 0; s < nsamp; s++) begin
            int t = 0;
            while (!out_valid && t < 20) begin
                tick;
                t++;
            end
            chk({nm, "_latency"}, t, 8);
            chk({nm, "_sample"}, int'(sample_out), e[s]);
            chk({nm, "_idx"}, int'(sample_idx), s);
            chk({nm, "_busy"}, int'(in_ready), 0);
            if (s == stall_at) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick;
                    chk({nm, "_stall_valid"}, int'(out_valid), 1);
                    chk({nm, "_stall_sample"}, int'(sample_out), e[s]);
                    chk({nm, "_stall_idx"}, int'(sample_idx), s);
                end
                out_ready = 1'b1;
            end
            tick;
        end
    endtask

    initial begin
        dc = '{35, 35, 35, 35, 35, 35, 35, 35};
        ac = '{31, 27, 18, 6, -6, -18, -27, -31};
        tv[0] = '{"dc",     '{100, 0, 0, 0, 0, 0, 0, 0},   dc};
        tv[1] = '{"ac",     '{0, 64, 0, 0, 0, 0, 0, 0},    ac};
        tv[2] = '{"sat_hi", '{1000, 0, 0, 0, 0, 0, 0, 0},  '{127, 127, 127, 127, 127, 127, 127, 127}};
        tv[3] = '{"sat_lo", '{-1000, 0, 0, 0, 0, 0, 0, 0}, '{-128, -128, -128, -128, -128, -128, -128, -128}};
        for (int i = 0; i < 8; i++) c[i] = '0;
        repeat (2) tick;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sample", int'(sample_out), 0);
        chk("rst_idx", int'(sample_idx), 0);
        chk("rst_ready", int'(in_ready), 1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            accept(tv[i].x);
            collect(tv[i].e, 8, -1, tv[i].name);
            chk({tv[i].name, "_done_ready"}, int'(in_ready), 1);
        end
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++)
                xr[k] = b == 5 ? int'($urandom_range(0, 524287)) - 262144
                               : int'($urandom_range(0, 4000)) - 2000;
            for (int n = 0; n < 8; n++) er[n] = model_sample(xr, n);
            accept(xr);
            collect(er, 8, -1, "rand");
            chk("rand_done_ready", int'(in_ready), 1);
        end
        accept(tv[0].x);
        collect(dc, 8, 3, "bp");
        chk("bp_done_ready", int'(in_ready), 1);
        accept(tv[1].x);
        for (int i = 0; i < 8; i++) c[i] = 19'(tv[0].x[i]);
        in_valid = 1'b1;
        collect(ac, 8, -1, "busy_first");
        chk("busy_idle_ready", int'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        chk("busy_second_taken", int'(in_ready), 0);
        collect(dc, 8, -1, "busy_second");
        accept(tv[0].x);
        collect(dc, 4, -1, "rst_pre");
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_sample", int'(sample_out), 0);
        chk("midrst_idx", int'(sample_idx), 0);
        chk("midrst_ready", int'(in_ready), 1);
        repeat (12) begin
            tick;
            chk("midrst_quiet", int'(out_valid), 0);
        end
        accept(tv[0].x);
        collect(dc, 8, -1, "rst_post");
        chk("rst_post_ready", int'(in_ready), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
